// File: rtl/zynet_pkg.sv
// zynet_pkg: shared types and helpers for the layer serializer slice
package zynet_pkg;
    typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;
    localparam int DATA_WIDTH_DEF = 16;
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/layer_shift_reg.sv
// layer_shift_reg: parallel-load, shift-down word register; q0 is the lowest word
module layer_shift_reg #(
    parameter int numNeuron = 30,
    parameter int dataWidth = 16
) (
    input  logic                           clk,
    input  logic                           load,
    input  logic                           shift,
    input  logic [numNeuron*dataWidth-1:0] d,
    output logic [dataWidth-1:0]           q0
);
    logic [numNeuron*dataWidth-1:0] mem;
    always_ff @(posedge clk) begin
        if (load) mem <= d;
        else if (shift) mem <= mem >> dataWidth;
    end
    assign q0 = mem[dataWidth-1:0];
endmodule

// File: rtl/layer_serializer.sv
// layer_serializer: captures a layer's parallel outputs and emits them one word per cycle
// Optional sticky overrun detection is enabled with LAYER_SER_OVERRUN_EN.
module layer_serializer
    import zynet_pkg::*;
#(
    parameter int numNeuron = 30,
    parameter int dataWidth = DATA_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [numNeuron-1:0]           x_valid,
    input  logic [numNeuron*dataWidth-1:0] x_in,
    output logic [dataWidth-1:0]           data_out,
    output logic                           data_out_valid,
    output logic                           busy,
    output logic                           overrun
);
    localparam int CW = cnt_w(numNeuron);
    localparam logic [CW-1:0] LAST = CW'(numNeuron - 1);
    ser_state_t state;
    logic [CW-1:0] cnt;
    logic [dataWidth-1:0] q0;
    logic load, shift, valid_unused;
    assign valid_unused = ^x_valid;
    assign load = (state == SER_IDLE) && x_valid[0];
    assign shift = (state == SER_SHIFT);
    assign busy = (state == SER_SHIFT);
    // word 0 goes straight to data_out at capture, so the buffer holds words 1..n-1
    layer_shift_reg #(.numNeuron(numNeuron), .dataWidth(dataWidth)) u_sr (
        .clk   (clk),
        .load  (load),
        .shift (shift),
        .d     (x_in >> dataWidth),
        .q0    (q0)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SER_IDLE;
            cnt <= '0;
            data_out <= '0;
            data_out_valid <= 1'b0;
        end else if (state == SER_IDLE) begin
            if (x_valid[0]) begin
                state <= SER_SHIFT;
                cnt <= '0;
                data_out <= x_in[dataWidth-1:0];
                data_out_valid <= 1'b1;
            end
        end else if (cnt == LAST) begin
            state <= SER_IDLE;
            data_out_valid <= 1'b0;
        end else begin
            data_out <= q0;
            cnt <= cnt + 1'b1;
        end
    end
`ifdef LAYER_SER_OVERRUN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) overrun <= 1'b0;
        else if (state == SER_SHIFT && x_valid[0]) overrun <= 1'b1;
    end
`else
    assign overrun = 1'b0;
`endif
endmodule
